// File: rtl/vg_pkg.sv
// Shared opcodes, FSM states and strobe sequencing tables for the vector generator.
// No logic latency: constants and pure functions only.
// No flow control: consumed by the fetch/decode FSM and its strobe sequencer.
package vg_pkg;

    localparam logic [2:0] OP_VCTR = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_SVEC = 3'b010;
    localparam logic [2:0] OP_STAT = 3'b011;
    localparam logic [2:0] OP_CNTR = 3'b100;
    localparam logic [2:0] OP_JSRL = 3'b101;
    localparam logic [2:0] OP_RTSL = 3'b110;
    localparam logic [2:0] OP_JMPL = 3'b111;

    localparam logic [1:0] CMD_VECTOR = 2'd0;
    localparam logic [1:0] CMD_CENTRE = 2'd1;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_START,
        ST_FETCH1,
        ST_FETCH2,
        ST_DECODE,
        ST_STACK_SEQ,
        ST_EXEC,
        ST_STATUS
    } vg_state_t;

    // Odd slots carry a single low strobe; even slots are idle gaps.
    function automatic logic [3:0] seq_slot(input logic [2:0] opc, input logic [2:0] idx);
        logic [3:0] s;
        s = 4'hF;
        if (opc == OP_JSRL) begin
            if (idx == 3'd1) s = 4'b1110;
            if (idx == 3'd3) s = 4'b1101;
            if (idx == 3'd5) s = 4'b1011;
        end else if (opc == OP_RTSL) begin
            if (idx == 3'd1) s = 4'b1101;
            if (idx == 3'd3) s = 4'b1011;
        end else if (opc == OP_JMPL) begin
            if (idx == 3'd1) s = 4'b1011;
        end else if (opc == OP_STAT) begin
            if (idx == 3'd1) s = 4'b0111;
        end
        return s;
    endfunction

    function automatic logic [2:0] seq_last(input logic [2:0] opc);
        logic [2:0] n;
        n = 3'd2;
        if (opc == OP_JSRL) n = 3'd6;
        if (opc == OP_RTSL) n = 3'd4;
        return n;
    endfunction

endpackage

// File: rtl/vg_strobe_seq.sv
// Generates the ordered, non-overlapping active-low stack/status strobes for one instruction.
// First strobe falls the cycle after start; done pulses one cycle after the trailing idle slot.
// No backpressure: runs to completion once started; op must stay stable until done.
module vg_strobe_seq
    import vg_pkg::*;
(
    input  logic       clk,
    input  logic       DISRST_not,
    input  logic       start,
    input  logic [2:0] op,
    output logic [3:0] strobe,
    output logic       done
);

    logic       active;
    logic [2:0] cnt;

    always_ff @(posedge clk or negedge DISRST_not) begin
        if (!DISRST_not) begin
            active <= 1'b0;
            cnt    <= 3'd0;
            strobe <= 4'hF;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= 3'd1;
                strobe <= seq_slot(op, 3'd1);
            end else if (active) begin
                if (cnt == seq_last(op)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                    strobe <= 4'hF;
                end else begin
                    cnt    <= cnt + 3'd1;
                    strobe <= seq_slot(op, cnt + 3'd1);
                end
            end
        end
    end

endmodule

// File: rtl/vg_fetch_decode.sv
// Vector generator fetch/decode/sequencing: reads instruction words, drives PC-stage controls and drawer commands.
// Per word: 1 cycle to raise mem_rd, ack wait, 1 AVG0 cycle; decode 1 cycle; stack ops add a strobe sequence.
// mem_rd held until mem_ack (timeout halts); vec_start pulse then waits on vec_done (same-cycle done allowed).
module vg_fetch_decode
    import vg_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        DISRST_not,
    input  logic        go,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        VGGO_not,
    output logic        AVG0,
    output logic [2:0]  op,
    output logic [3:0]  strobe,
    output logic [11:0] DVY,
    output logic        vec_start,
    input  logic        vec_done,
    output logic [1:0]  vec_cmd,
    output logic [12:0] vec_dx,
    output logic [12:0] vec_dy,
    output logic [2:0]  vec_z,
    output logic [3:0]  stat_color,
    output logic [3:0]  stat_int,
    output logic [2:0]  scal_bin,
    output logic [7:0]  scal_lin,
    output logic        halted
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    vg_state_t         state;
    logic [15:0]       word1;
    logic [WAIT_W-1:0] wait_cnt;
    logic              seq_start;
    logic              seq_done;
    logic [2:0]        opc;

    assign opc = word1[15:13];

    vg_strobe_seq u_seq (
        .clk        (clk),
        .DISRST_not (DISRST_not),
        .start      (seq_start),
        .op         (op),
        .strobe     (strobe),
        .done       (seq_done)
    );

    always_ff @(posedge clk or negedge DISRST_not) begin
        if (!DISRST_not) begin
            state      <= ST_HALT;
            word1      <= 16'h0000;
            wait_cnt   <= '0;
            seq_start  <= 1'b0;
            mem_rd     <= 1'b0;
            VGGO_not   <= 1'b1;
            AVG0       <= 1'b0;
            op         <= OP_VCTR;
            DVY        <= 12'h000;
            vec_start  <= 1'b0;
            vec_cmd    <= CMD_VECTOR;
            vec_dx     <= 13'h0000;
            vec_dy     <= 13'h0000;
            vec_z      <= 3'd0;
            stat_color <= 4'h0;
            stat_int   <= 4'h0;
            scal_bin   <= 3'd0;
            scal_lin   <= 8'h00;
            halted     <= 1'b1;
        end else begin
            vec_start <= 1'b0;
            seq_start <= 1'b0;
            case (state)
                ST_HALT: begin
                    if (go) begin
                        VGGO_not <= 1'b0;
                        halted   <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    VGGO_not <= 1'b1;
                    state    <= ST_FETCH1;
                end
                // Three phases per word: raise mem_rd, wait for ack, then one AVG0 cycle.
                ST_FETCH1, ST_FETCH2: begin
                    if (AVG0) begin
                        AVG0 <= 1'b0;
                        if (state == ST_FETCH1) begin
                            state <= ST_DECODE;
                        end else begin
                            vec_start <= 1'b1;
                            state     <= ST_EXEC;
                        end
                    end else if (mem_rd) begin
                        if (mem_ack) begin
                            mem_rd <= 1'b0;
                            AVG0   <= 1'b1;
                            if (state == ST_FETCH1) begin
                                word1 <= mem_data;
                            end else begin
                                vec_dx <= mem_data[12:0];
                                vec_z  <= mem_data[15:13];
                            end
                        end else if (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                            mem_rd <= 1'b0;
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        mem_rd   <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                ST_DECODE: begin
                    op <= (opc == OP_HALT) ? OP_VCTR : opc;
                    case (opc)
                        OP_VCTR: begin
                            vec_cmd <= CMD_VECTOR;
                            vec_dy  <= word1[12:0];
                            state   <= ST_FETCH2;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= ST_HALT;
                        end
                        OP_SVEC: begin
                            vec_cmd   <= CMD_VECTOR;
                            vec_dy    <= {{7{word1[12]}}, word1[12:8], 1'b0};
                            vec_dx    <= {{7{word1[4]}}, word1[4:0], 1'b0};
                            vec_z     <= word1[7:5];
                            vec_start <= 1'b1;
                            state     <= ST_EXEC;
                        end
                        OP_STAT: begin
                            if (word1[12]) begin
                                scal_bin <= word1[10:8];
                                scal_lin <= word1[7:0];
                            end else begin
                                stat_int   <= word1[7:4];
                                stat_color <= word1[3:0];
                            end
                            seq_start <= 1'b1;
                            state     <= ST_STATUS;
                        end
                        OP_CNTR: begin
                            vec_cmd   <= CMD_CENTRE;
                            vec_start <= 1'b1;
                            state     <= ST_EXEC;
                        end
                        default: begin
                            if (opc != OP_RTSL) DVY <= word1[11:0];
                            seq_start <= 1'b1;
                            state     <= ST_STACK_SEQ;
                        end
                    endcase
                end
                // op holds through the sequencer's trailing idle so the PC stage sees it settle.
                ST_STACK_SEQ, ST_STATUS: begin
                    if (seq_done) begin
                        op    <= OP_VCTR;
                        state <= ST_FETCH1;
                    end
                end
                ST_EXEC: begin
                    if (vec_done) begin
                        vec_cmd <= CMD_VECTOR;
                        op      <= OP_VCTR;
                        state   <= ST_FETCH1;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_vg_fetch_decode.sv
// Directed bench for vg_fetch_decode: word-stream memory responder, drawer responder and event monitor.
// Expected values are hand-computed from the instruction encodings.
module tb_vg_fetch_decode;

    logic        clk = 1'b0;
    logic        DISRST_not;
    logic        go;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        VGGO_not;
    logic        AVG0;
    logic [2:0]  op;
    logic [3:0]  strobe;
    logic [11:0] DVY;
    logic        vec_start;
    logic        vec_done;
    logic [1:0]  vec_cmd;
    logic [12:0] vec_dx;
    logic [12:0] vec_dy;
    logic [2:0]  vec_z;
    logic [3:0]  stat_color;
    logic [3:0]  stat_int;
    logic [2:0]  scal_bin;
    logic [7:0]  scal_lin;
    logic        halted;

    vg_fetch_decode #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .DISRST_not (DISRST_not),
        .go         (go),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .VGGO_not   (VGGO_not),
        .AVG0       (AVG0),
        .op         (op),
        .strobe     (strobe),
        .DVY        (DVY),
        .vec_start  (vec_start),
        .vec_done   (vec_done),
        .vec_cmd    (vec_cmd),
        .vec_dx     (vec_dx),
        .vec_dy     (vec_dy),
        .vec_z      (vec_z),
        .stat_color (stat_color),
        .stat_int   (stat_int),
        .scal_bin   (scal_bin),
        .scal_lin   (scal_lin),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:63];
    int  rd_ptr     = 0;
    bit  ack_en     = 1'b1;
    bit  done_en    = 1'b1;
    bit  force_ack  = 1'b0;
    bit  force_done = 1'b0;

    // Memory and drawer responders: react at the falling edge so the DUT samples a settled value.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        vec_done = 1'b0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                mem_ack  = 1'b1;
                mem_data = 16'hFFFF;
            end else if (mem_rd && ack_en) begin
                mem_ack  = 1'b1;
                mem_data = mem[rd_ptr];
                rd_ptr++;
            end else begin
                mem_ack = 1'b0;
            end
            vec_done = (vec_start && done_en) || force_done;
        end
    end

    int          cyc = 0;
    int          avg0_n = 0, memrd_n = 0, vggo_n = 0, vs_n = 0, st_n = 0, overlap_n = 0;
    int          vs_avg0 = 0;
    logic [1:0]  vs_cmd = 2'd0;
    logic        vggo_halted = 1'b1;
    logic [2:0]  prev_op = 3'd0;
    logic [3:0]  st_val     [0:31];
    int          st_cyc     [0:31];
    logic [2:0]  st_op      [0:31];
    logic [2:0]  st_prev_op [0:31];
    logic [11:0] st_dvy     [0:31];

    always @(negedge clk) begin
        if (AVG0) avg0_n++;
        if (mem_rd) memrd_n++;
        if (!VGGO_not) begin
            vggo_n++;
            vggo_halted = halted;
        end
        if (vec_start) begin
            vs_n++;
            vs_avg0 = avg0_n;
            vs_cmd  = vec_cmd;
        end
        if (strobe != 4'hF && st_n < 32) begin
            st_val[st_n]     = strobe;
            st_cyc[st_n]     = cyc;
            st_op[st_n]      = op;
            st_prev_op[st_n] = prev_op;
            st_dvy[st_n]     = DVY;
            if ($countones(~strobe) > 1) overlap_n++;
            st_n++;
        end
        prev_op = op;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
        mem[rd_ptr]     = w0;
        mem[rd_ptr + 1] = w1;
        mem[rd_ptr + 2] = w2;
        mem[rd_ptr + 3] = w3;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_halt(input string tag, input int limit);
        bit ok;
        go = 1'b1;
        step();
        go = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({tag, " reaches halt"}, 32'(ok), 1);
    endtask

    int         b_av, b_vg, b_vs, b_st, b_mr;
    logic [3:0] exp_st [0:4];
    logic [2:0] exp_op [0:4];

    initial begin
        DISRST_not = 1'b0;
        go         = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h2000;
        #12;
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst VGGO_not", 32'(VGGO_not), 1);
        chk("rst AVG0", 32'(AVG0), 0);
        chk("rst op", 32'(op), 0);
        chk("rst strobe", 32'(strobe), 32'hF);
        chk("rst DVY", 32'(DVY), 0);
        chk("rst vec_start", 32'(vec_start), 0);
        chk("rst vec_cmd", 32'(vec_cmd), 0);
        chk("rst vec_dxdy", 32'({vec_dx, vec_dy}), 0);
        chk("rst regs", 32'({vec_z, stat_color, stat_int, scal_bin, scal_lin}), 0);
        chk("rst halted", 32'(halted), 1);
        step();
        DISRST_not = 1'b1;
        step();

        // HALT only
        load(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        b_av = avg0_n; b_vg = vggo_n; b_vs = vs_n;
        run_to_halt("halt", 200);
        chk("halt VGGO_not low cycles", 32'(vggo_n - b_vg), 1);
        chk("halt halted during VGGO", 32'(vggo_halted), 0);
        chk("halt AVG0 pulses", 32'(avg0_n - b_av), 1);
        chk("halt vec_start count", 32'(vs_n - b_vs), 0);
        chk("halt op idle", 32'(op), 0);

        // VCTR then HALT
        load(16'h1F00, 16'hA005, 16'h2000, 16'h2000);
        b_av = avg0_n; b_vs = vs_n;
        run_to_halt("vctr", 200);
        chk("vctr vec_dy", 32'(vec_dy), 32'h1F00);
        chk("vctr vec_dx", 32'(vec_dx), 32'h0005);
        chk("vctr vec_z", 32'(vec_z), 5);
        chk("vctr vec_start count", 32'(vs_n - b_vs), 1);
        chk("vctr AVG0 before start", 32'(vs_avg0 - b_av), 2);
        chk("vctr vec_cmd at start", 32'(vs_cmd), 0);
        chk("vctr AVG0 total", 32'(avg0_n - b_av), 3);

        // SVEC, SCAL, STAT, HALT
        load(16'h5F9F, 16'h7305, 16'h60A7, 16'h2000);
        b_st = st_n; b_vs = vs_n;
        run_to_halt("svec", 300);
        chk("svec vec_dy", 32'(vec_dy), 32'h1FFE);
        chk("svec vec_dx", 32'(vec_dx), 32'h1FFE);
        chk("svec vec_z", 32'(vec_z), 4);
        chk("svec vec_start count", 32'(vs_n - b_vs), 1);
        chk("scal scal_bin", 32'(scal_bin), 3);
        chk("scal scal_lin", 32'(scal_lin), 32'h05);
        chk("stat stat_int", 32'(stat_int), 32'hA);
        chk("stat stat_color", 32'(stat_color), 7);
        chk("stat strobe events", 32'(st_n - b_st), 2);
        chk("scal strobe value", 32'(st_val[b_st]), 32'h7);
        chk("stat strobe value", 32'(st_val[b_st + 1]), 32'h7);

        // CNTR
        load(16'h8000, 16'h2000, 16'h2000, 16'h2000);
        b_vs = vs_n;
        run_to_halt("cntr", 200);
        chk("cntr vec_start count", 32'(vs_n - b_vs), 1);
        chk("cntr vec_cmd at start", 32'(vs_cmd), 1);
        chk("cntr vec_cmd after", 32'(vec_cmd), 0);

        // JSRL then RTSL
        exp_st[0] = 4'b1110; exp_st[1] = 4'b1101; exp_st[2] = 4'b1011;
        exp_st[3] = 4'b1101; exp_st[4] = 4'b1011;
        exp_op[0] = 3'b101;  exp_op[1] = 3'b101;  exp_op[2] = 3'b101;
        exp_op[3] = 3'b110;  exp_op[4] = 3'b110;
        load(16'hA040, 16'hC000, 16'h2000, 16'h2000);
        b_st = st_n;
        run_to_halt("jsrl", 300);
        chk("jsrl strobe events", 32'(st_n - b_st), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stack strobe %0d value", k), 32'(st_val[b_st + k]), 32'(exp_st[k]));
            chk($sformatf("stack strobe %0d op", k), 32'(st_op[b_st + k]), 32'(exp_op[k]));
        end
        chk("jsrl gap 0-1", 32'(st_cyc[b_st + 1] - st_cyc[b_st]), 2);
        chk("jsrl gap 1-2", 32'(st_cyc[b_st + 2] - st_cyc[b_st + 1]), 2);
        chk("rtsl gap", 32'(st_cyc[b_st + 4] - st_cyc[b_st + 3]), 2);
        chk("jsrl op setup", 32'(st_prev_op[b_st]), 32'h5);
        chk("rtsl op setup", 32'(st_prev_op[b_st + 3]), 32'h6);
        chk("jsrl DVY at strobe", 32'(st_dvy[b_st + 2]), 32'h040);
        chk("strobe overlap", 32'(overlap_n), 0);
        chk("jsrl op idle after", 32'(op), 0);

        // memory timeout
        ack_en = 1'b0;
        b_mr = memrd_n;
        run_to_halt("timeout", 100);
        chk("timeout mem_rd cycles", 32'(memrd_n - b_mr), 15);
        chk("timeout mem_rd low", 32'(mem_rd), 0);
        ack_en = 1'b1;

        // reset during EXEC; late vec_done and mem_ack ignored
        done_en = 1'b0;
        load(16'h8000, 16'h2000, 16'h2000, 16'h2000);
        b_vs = vs_n;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < 100 && vs_n == b_vs; i++) step();
        chk("exec vec_start seen", 32'(vs_n - b_vs), 1);
        step();
        step();
        chk("exec waiting", 32'({halted, vec_cmd}), 32'h1);
        DISRST_not = 1'b0;
        #1;
        chk("mid rst halted", 32'(halted), 1);
        chk("mid rst vec_cmd", 32'(vec_cmd), 0);
        chk("mid rst op", 32'(op), 0);
        chk("mid rst strobe/mem_rd", 32'({strobe, mem_rd, AVG0}), 32'h3C);
        step();
        DISRST_not = 1'b1;
        b_vs = vs_n; b_av = avg0_n;
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        force_ack  = 1'b1;
        step();
        force_ack = 1'b0;
        repeat (3) step();
        chk("post rst halted", 32'(halted), 1);
        chk("post rst vec_start", 32'(vs_n - b_vs), 0);
        chk("post rst AVG0", 32'(avg0_n - b_av), 0);
        chk("post rst mem_rd/VGGO_not", 32'({mem_rd, VGGO_not}), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
